// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, frame geometry
// and baud divider arithmetic.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int FRAME_BITS = 10;
   localparam int DATA_BITS  = 8;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   // Counter width that still works when the terminal count is 1.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO; full/empty are registered so downstream
// ready signals carry no combinational path from the push request.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      cnt_n;
   logic             do_push;
   logic             do_pop;

   // A pop in the same cycle never frees room for a push into a full FIFO.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      cnt_n = count;
      if (do_push && !do_pop)
         cnt_n = count + 1'b1;
      else if (!do_push && do_pop)
         cnt_n = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         count <= cnt_n;
         full  <= (cnt_n == (AW+1)'(DEPTH));
         empty <= (cnt_n == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   assign rdata = mem[rptr];

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO; the line is driven from a
// flop whose next value is decided together with the FSM transition.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 100000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       TX,
   output logic       busy
);

   localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
   localparam int BW  = cnt_w(CPB);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

   state_t                      state, state_n;
   logic [BW-1:0]               baud_q, baud_n;
   logic [2:0]                  bit_q, bit_n;
   logic [7:0]                  shift_q, shift_n;
   logic                        tx_q, tx_n;
   logic                        pop;
   logic                        baud_done;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [7:0]                  fifo_rdata;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   // fifo_full is itself a flop, so tx_ready never depends on tx_valid.
   assign tx_ready = !fifo_full;

   uart_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_valid && tx_ready),
      .pop   (pop),
      .wdata (tx_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign baud_done = (baud_q == BAUD_LAST);

   always_comb begin
      state_n = state;
      baud_n  = baud_q;
      bit_n   = bit_q;
      shift_n = shift_q;
      tx_n    = tx_q;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            tx_n   = 1'b1;
            baud_n = '0;
            bit_n  = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_n = fifo_rdata;
               state_n = START;
               tx_n    = 1'b0;
            end
         end
         START: begin
            if (baud_done) begin
               baud_n  = '0;
               bit_n   = '0;
               state_n = DATA;
               tx_n    = shift_q[0];
            end else begin
               baud_n = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_n = '0;
               if (bit_q == BIT_LAST) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_n   = bit_q + 3'd1;
                  shift_n = shift_q >> 1;
                  tx_n    = shift_q[1];
               end
            end else begin
               baud_n = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_n = '0;
               // Chain straight into the next start bit to keep bursts gapless.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_n = fifo_rdata;
                  state_n = START;
                  tx_n    = 1'b0;
               end else begin
                  state_n = IDLE;
                  tx_n    = 1'b1;
               end
            end else begin
               baud_n = baud_q + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state   <= state_n;
         baud_q  <= baud_n;
         bit_q   <= bit_n;
         shift_q <= shift_n;
         tx_q    <= tx_n;
      end
   end

   assign TX   = tx_q;
   assign busy = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: vector table of single frames, hand-written burst/stall/
// reset sequences, random traffic against a cycle-level line model.
module tb_uart_tx;

   localparam int CLK_HZ = 10_000_000;
   localparam int BAUD   = 115_200;
   localparam int DEPTH  = 4;
   localparam int CPB    = CLK_HZ / BAUD;   // 86
   localparam int FRAME  = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       TX;
   logic       busy;

   uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .TX       (TX),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model: accepted-byte queue + ideal line ----
   typedef struct {
      logic [7:0] data;
      int         acc;
   } ent_t;

   ent_t       mq[$];
   logic [7:0] acc_log[$];
   logic [7:0] rx_q[$];
   int         starts_q[$];
   int         cyc = 0;
   int         fstart = 0;
   int         fend = 0;
   logic [9:0] fpat = 10'h3FF;
   bit         rst_prev = 1'b1;
   int         err_tx = 0, err_busy = 0, err_rdy = 0, err_frm = 0;
   bit         d_act = 1'b0;
   int         d_cnt = 0;
   logic [7:0] d_byte = 8'h00;
   logic       tx_prev = 1'b1;

   // Negedge k observes the state after posedge k; inputs seen here are
   // the ones the DUT samples at posedge k+1.
   always @(negedge clk) begin : mon
      logic exp_tx;
      int   bi;
      if (rst_prev) begin
         mq.delete();
         fend = 0;
      end else begin
         if (cyc >= fend && mq.size() > 0 && mq[0].acc <= cyc - 1) begin
            fstart = cyc;
            fend   = cyc + FRAME;
            fpat   = {1'b1, mq[0].data, 1'b0};
            void'(mq.pop_front());
         end
         exp_tx = (cyc < fend) ? fpat[(cyc - fstart) / CPB] : 1'b1;
         if (TX !== exp_tx) err_tx++;
         if (busy !== ((cyc < fend) || (mq.size() > 0))) err_busy++;
         if (tx_ready !== (mq.size() < DEPTH)) err_rdy++;
      end
      if (!rst && tx_valid && tx_ready) begin
         mq.push_back('{data: tx_data, acc: cyc + 1});
         acc_log.push_back(tx_data);
      end
      // independent mid-bit serial receiver
      if (rst) begin
         d_act = 1'b0;
      end else begin
         if (!d_act && TX === 1'b0 && tx_prev === 1'b1) begin
            d_act = 1'b1;
            d_cnt = 0;
            starts_q.push_back(cyc);
         end else if (d_act) begin
            d_cnt++;
         end
         if (d_act && (d_cnt % CPB) == CPB / 2) begin
            bi = d_cnt / CPB;
            if (bi == 0 && TX !== 1'b0) err_frm++;
            if (bi >= 1 && bi <= 8) d_byte[bi-1] = TX;
            if (bi == 9) begin
               if (TX !== 1'b1) err_frm++;
               rx_q.push_back(d_byte);
               d_act = 1'b0;
            end
         end
      end
      tx_prev  = TX;
      rst_prev = rst;
      cyc++;
   end

   task automatic send(input logic [7:0] d, input string nm);
      int n = 0;
      tx_data  = d;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && n < 4 * FRAME) begin
         tick();
         n++;
      end
      check({nm, "_accept_to"}, (n < 4 * FRAME), 1);
      tick();
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy !== 1'b0 && n < 20 * FRAME) begin
         tick();
         n++;
      end
      check({nm, "_idle"}, busy, 0);
      repeat (2) tick();
   endtask

   typedef struct {
      logic [7:0] data;
      int         lead;   // bit periods low from the start bit onward
   } vec_t;

   vec_t vt[7];

   initial begin
      int         bcnt, lcnt, nxt, before_drop, n, rdy_hi, low_n, busy_n, bad;
      bit         hi, dropped, r;
      logic [7:0] got;

      vt[0] = '{8'h41, 1};
      vt[1] = '{8'h00, 9};
      vt[2] = '{8'hFF, 1};
      vt[3] = '{8'h80, 8};
      vt[4] = '{8'h02, 2};
      vt[5] = '{8'h10, 5};
      vt[6] = '{8'hA5, 1};

      // reset state
      rst = 1'b1;
      repeat (3) tick();
      check("rst_tx", TX, 1);
      check("rst_busy", busy, 0);
      check("rst_ready", tx_ready, 1);
      rst = 1'b0;
      repeat (2) tick();

      // single frames from idle, table driven
      foreach (vt[i]) begin
         rx_q.delete();
         tx_data  = vt[i].data;
         tx_valid = 1'b1;
         tick();
         tx_valid = 1'b0;
         check("lat_pre", TX, 1);
         tick();
         check("lat_low", TX, 0);
         bcnt = 0; lcnt = 0; hi = 1'b0;
         while (busy === 1'b1 && bcnt < 2 * FRAME) begin
            if (!hi && TX === 1'b0) lcnt++;
            else hi = 1'b1;
            bcnt++;
            tick();
         end
         check("lead_low", lcnt, vt[i].lead * CPB);
         check("frame_len", bcnt, FRAME);
         got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
         check("decode", got, vt[i].data);
         repeat (3) tick();
      end

      // burst 0x01..0x06 with tx_valid held high
      rx_q.delete();
      starts_q.delete();
      nxt = 1; before_drop = 0; dropped = 1'b0; n = 0;
      tx_data  = 8'h01;
      tx_valid = 1'b1;
      while (nxt <= 6 && n < 10 * FRAME) begin
         r = tx_ready;
         tick();
         n++;
         if (r) begin
            if (!dropped) before_drop++;
            nxt++;
            tx_data = 8'(nxt);
         end else begin
            dropped = 1'b1;
         end
      end
      tx_valid = 1'b0;
      check("burst_pre_drop", before_drop, 5);
      check("burst_all_acc", nxt, 7);
      wait_idle("burst");
      check("burst_nrx", rx_q.size(), 6);
      for (int i = 0; i < 6; i++) begin
         got = (rx_q.size() > i) ? rx_q[i] : 8'hxx;
         check("burst_order", got, 8'(i + 1));
      end
      for (int i = 1; i < 6; i++) begin
         if (starts_q.size() > i) check("burst_gap", starts_q[i] - starts_q[i-1], FRAME);
         else check("burst_gap", 0, FRAME);
      end

      // stall with FIFO full for 100 cycles
      rx_q.delete();
      for (int i = 0; i < 5; i++) send(8'hC1 + 8'(i), "stall");
      rdy_hi = 0;
      for (int i = 0; i < 100; i++) begin
         tx_data = 8'($urandom);
         if (tx_ready !== 1'b0) rdy_hi++;
         tick();
      end
      tx_valid = 1'b0;
      check("stall_ready_low", rdy_hi, 0);
      wait_idle("stall");
      check("stall_nrx", rx_q.size(), 5);
      for (int i = 0; i < 5; i++) begin
         got = (rx_q.size() > i) ? rx_q[i] : 8'hxx;
         check("stall_order", got, 8'hC1 + 8'(i));
      end

      // reset during data bit 3 with two bytes queued
      rx_q.delete();
      starts_q.delete();
      send(8'h5A, "rstm");
      send(8'h33, "rstm");
      send(8'hCC, "rstm");
      tx_valid = 1'b0;
      n = 0;
      while ((starts_q.size() == 0 || cyc - starts_q[0] < 4 * CPB + CPB / 2) && n < 2 * FRAME) begin
         tick();
         n++;
      end
      check("rstm_reach_bit3", (n < 2 * FRAME), 1);
      rst      = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h99;
      tick();
      check("rstm_tx", TX, 1);
      check("rstm_busy", busy, 0);
      check("rstm_ready", tx_ready, 1);
      repeat (2) tick();
      rst      = 1'b0;
      tx_valid = 1'b0;
      low_n = 0; busy_n = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         if (TX !== 1'b1) low_n++;
         if (busy !== 1'b0) busy_n++;
         tick();
      end
      check("rstm_no_tx", low_n, 0);
      check("rstm_no_busy", busy_n, 0);
      check("rstm_no_rx", rx_q.size(), 0);

      // random traffic against the model
      rx_q.delete();
      acc_log.delete();
      for (int i = 0; i < 24; i++) begin
         send(8'($urandom), "rand");
         tx_valid = 1'b0;
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 2 * FRAME)) tick();
         else repeat ($urandom_range(0, 5)) tick();
      end
      wait_idle("rand");
      check("rand_nacc", acc_log.size(), 24);
      check("rand_nrx", rx_q.size(), 24);
      bad = 0;
      for (int i = 0; i < 24; i++) begin
         if (rx_q.size() <= i || acc_log.size() <= i || rx_q[i] !== acc_log[i]) bad++;
      end
      check("rand_order", bad, 0);

      check("model_tx", err_tx, 0);
      check("model_busy", err_busy, 0);
      check("model_ready", err_rdy, 0);
      check("rx_framing", err_frm, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
